// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode
// and execute steps, plus the ALU-operation and immediate-format decoders.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StAluWb    = 4'd7,
    StExecuteI = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] alu_decoded;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  // State register with synchronous reset back to fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operation from funct fields; only R-type may turn funct3 000 into sub.
  always_comb begin
    alu_decoded = AluAdd;
    case (funct3)
      3'b000:  alu_decoded = (op == OpRtype && funct7b5) ? AluSub : AluAdd;
      3'b111:  alu_decoded = AluAnd;
      3'b110:  alu_decoded = AluOr;
      default: alu_decoded = AluAdd;
    endcase
  end

  // Immediate format is a pure function of the opcode in every state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  // Next-state and Moore outputs; pc_write in BEQ is the only input-dependent output.
  always_comb begin
    state_d       = StFetch;
    pc_write_raw  = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    reg_write_raw = 1'b0;
    alucontrol    = AluAdd;
    case (state_q)
      StFetch: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBeq;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StExecuteR: begin
        alu_src_a  = 2'b10;
        alucontrol = alu_decoded;
        state_d    = StAluWb;
      end
      StExecuteI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alucontrol = alu_decoded;
        state_d    = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = StAluWb;
      end
      StBeq: begin
        alu_src_a    = 2'b10;
        alucontrol   = AluSub;
        pc_write_raw = zero && (funct3 == 3'b000);
        state_d      = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted.
  assign pc_write  = pc_write_raw & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign ir_write  = ir_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions compared
// cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int unsigned total = 0;
  int unsigned passed = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Visited states of one instruction, one nibble per cycle, first cycle lowest.
  function automatic logic [31:0] ref_path(input logic [6:0] o);
    case (o)
      LW:      return 32'h43210;
      SW:      return 32'h5210;
      RTY:     return 32'h7610;
      ITY:     return 32'h7810;
      JAL:     return 32'h7910;
      BEQ:     return 32'hA10;
      default: return 32'h10;
    endcase
  endfunction

  // Cycles per instruction.
  function automatic int ref_len(input logic [6:0] o);
    case (o)
      LW:                 return 5;
      SW, RTY, ITY, JAL:  return 4;
      BEQ:                return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b111) return 3'd2;
    if (f3 == 3'b110) return 3'd3;
    if (f3 == 3'b000 && o == RTY && f7) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == SW)  return 2'd1;
    if (o == BEQ) return 2'd2;
    if (o == JAL) return 2'd3;
    return 2'd0;
  endfunction

  // Expected output vector for a given state and inputs.
  function automatic logic [19:0] ref_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic r);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    {pcw, adr, mw, irw, rw} = '0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; ac = 3'd0;
    case (st)
      0:  begin irw = 1; sb = 2'd2; rs = 2'd2; pcw = 1; end
      1:  begin sa = 2'd1; sb = 2'd1; end
      2:  begin sa = 2'd2; sb = 2'd1; end
      3:  adr = 1;
      4:  begin rs = 2'd1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'd2; ac = ref_alu(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2'd2; sb = 2'd1; ac = ref_alu(o, f3, f7); end
      9:  begin sa = 2'd1; sb = 2'd2; pcw = 1; end
      10: begin sa = 2'd2; ac = 3'd1; pcw = z && (f3 == 3'b000); end
      default: ;
    endcase
    if (r) begin
      pcw = 0; mw = 0; irw = 0; rw = 0;
    end
    return {pcw, adr, mw, irw, rs, sa, sb, ref_imm(o), rw, ac, 4'(st)};
  endfunction

  function automatic logic [19:0] observed();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src,
            reg_write, alucontrol, state};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
  endtask

  // Runs one instruction from its fetch cycle. Fields are only held valid in
  // the states that consume them; elsewhere they are scrambled. abort_k >= 0
  // raises reset in that cycle and ends the instruction there.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int abort_k);
    logic [31:0] path;
    int          len;
    int          st;
    path = ref_path(o);
    len  = ref_len(o);
    for (int k = 0; k < len; k++) begin
      st = int'((path >> (4 * k)) & 32'hF);
      if (k == abort_k) rst = 1'b1;
      if (st == 1 || st == 2 || st == 6 || st == 8 || st == 10) begin
        op = o; funct3 = f3; funct7b5 = f7;
      end else begin
        op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      end
      zero = (st == 10) ? z : 1'($urandom);
      #1;
      check($sformatf("%s cyc%0d st%0d", name, k, st), observed(),
            ref_out(st, op, funct3, funct7b5, zero, rst));
      @(negedge clk);
      if (k == abort_k) break;
    end
    if (abort_k >= 0) begin
      #1;
      check($sformatf("%s abort_to_fetch", name), observed(),
            ref_out(0, op, funct3, funct7b5, zero, 1'b1));
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] o;
    logic [2:0] f3;
    int         ab;
    ops = '{LW, SW, RTY, ITY, JAL, BEQ, LUI};
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

    // Two reset cycles: fetch state, write enables held low.
    @(negedge clk); #1;
    check("reset_cyc1", observed(), ref_out(0, op, funct3, funct7b5, zero, 1'b1));
    @(negedge clk); #1;
    check("reset_cyc2", observed(), ref_out(0, op, funct3, funct7b5, zero, 1'b1));
    rst = 1'b0;

    run_instr("lw",        LW,  3'b010, 1'b0, 1'b0, -1);
    run_instr("sub",       RTY, 3'b000, 1'b1, 1'b0, -1);
    run_instr("or",        RTY, 3'b110, 1'b0, 1'b0, -1);
    run_instr("addi_f7",   ITY, 3'b000, 1'b1, 1'b0, -1);
    run_instr("andi",      ITY, 3'b111, 1'b0, 1'b0, -1);
    run_instr("sw",        SW,  3'b010, 1'b0, 1'b0, -1);
    run_instr("jal",       JAL, 3'b000, 1'b0, 1'b0, -1);
    run_instr("beq_taken", BEQ, 3'b000, 1'b0, 1'b1, -1);
    run_instr("beq_nz",    BEQ, 3'b000, 1'b0, 1'b0, -1);
    run_instr("bne_f3",    BEQ, 3'b001, 1'b0, 1'b1, -1);
    run_instr("lui_unsup", LUI, 3'b000, 1'b0, 1'b0, -1);
    run_instr("lw_abort",  LW,  3'b010, 1'b0, 1'b0, 3);
    run_instr("post_abort", RTY, 3'b111, 1'b0, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      o  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(1, ref_len(o) - 1) : -1;
      run_instr($sformatf("rand%0d", n), o, f3, 1'($urandom), 1'($urandom), ab);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op  input  7  instruction opcode field from the instruction register.
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag (result == 0).
REQ-008 pc_write  output  1  PC register load enable.
REQ-009 adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write  output  1  data memory write enable.
REQ-011 ir_write  output  1  instruction register and old-PC load enable.
REQ-012 result_src  output  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-013 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-014 alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-015 imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 reg_write  output  1  register file write enable.
REQ-017 alucontrol  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or.
REQ-018 state  output  4  current FSM state code, for debug.

Function
REQ-019 The FSM SHALL use these state codes: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10.
REQ-020 Every output not listed for a state SHALL be 0 in that state; all outputs SHALL be combinational from state (Moore), except pc_write in BEQ.
REQ-021 FETCH: adr_src = 0, ir_write = 1, alu_src_a = 00, alu_src_b = 10, alucontrol = add, result_src = 10, pc_write = 1; next state DECODE.
REQ-022 DECODE: alu_src_a = 01, alu_src_b = 01, alucontrol = add.
REQ-023 DECODE next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH.
REQ-024 MEMADR: alu_src_a = 10, alu_src_b = 01, alucontrol = add; next state MEMREAD if op = 0000011, else MEMWRITE.
REQ-025 MEMREAD: result_src = 00, adr_src = 1; next state MEMWB.
REQ-026 MEMWB: result_src = 01, reg_write = 1; next state FETCH.
REQ-027 MEMWRITE: result_src = 00, adr_src = 1, mem_write = 1; next state FETCH.
REQ-028 EXECUTER: alu_src_a = 10, alu_src_b = 00, alucontrol from the ALU decode (REQ-033); next state ALUWB.
REQ-029 EXECUTEI: alu_src_a = 10, alu_src_b = 01, alucontrol from the ALU decode; next state ALUWB.
REQ-030 ALUWB: result_src = 00, reg_write = 1; next state FETCH.
REQ-031 JAL: alu_src_a = 01, alu_src_b = 10, alucontrol = add, result_src = 00, pc_write = 1; next state ALUWB.
REQ-032 BEQ: alu_src_a = 10, alu_src_b = 00, alucontrol = sub, result_src = 00, pc_write = zero AND (funct3 == 000); next state FETCH.
REQ-033 ALU decode:
- funct3 000 -> sub if op = 0110011 and funct7b5 = 1, otherwise add.
- funct3 111 -> and.
- funct3 110 -> or.
- any other funct3 -> add.
REQ-034 imm_src SHALL decode from op in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other op values -> 00.
REQ-035 Cycles per instruction SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, unsupported op 2.
REQ-036 op and funct fields SHALL be sampled only in DECODE, MEMADR, EXECUTER, EXECUTEI and BEQ; changes in other states SHALL have no effect.

Reset
REQ-037 When rst = 1 at a rising edge, state SHALL become FETCH, regardless of current state, including mid-instruction.
REQ-038 While rst = 1, pc_write, ir_write, mem_write and reg_write SHALL be forced to 0.
REQ-039 The first FETCH after rst deasserts SHALL drive ir_write = 1 and pc_write = 1.

Verification
REQ-040 Reset sequence: rst high for 2 cycles, then low -> state = 0 with all write enables 0 during reset; FETCH enables asserted in the first cycle after release.
REQ-041 lw (op 0000011) -> state sequence 0,1,2,3,4,0; reg_write = 1 only in state 4 with result_src = 01.
REQ-042 sub (op 0110011, funct3 000, funct7b5 1) -> sequence 0,1,6,7,0; alucontrol = 001 in state 6; or (funct3 110) -> alucontrol = 011.
REQ-043 beq with zero = 1 -> pc_write = 1 in state 10; repeated with zero = 0 -> pc_write = 0; with funct3 001 and zero = 1 -> pc_write = 0.
REQ-044 Unsupported op 0110111 -> sequence 0,1,0 with no reg_write or mem_write asserted.
REQ-045 rst asserted while in MEMREAD -> next state 0; no mem_write or reg_write pulse occurs for the aborted instruction.
